// File: rtl/lp805x_clken_gen.sv
`default_nettype none
// ============================================================================
// Module   : lp805x_clken_gen
// Brief    : Lock-gated divided clock-enable generator with a handshaked,
//            pulse-boundary-safe selected enable. Optional lock monitor
//            enabled by macro LP805X_CLKEN_LOCKMON_EN.
// Revision : 1.0
// ============================================================================
module lp805x_clken_gen #(
    parameter int NCH      = 4,
    parameter int SEL_W    = 2,
    parameter int DIV_W    = 8,
    parameter int LOCK_CYC = 16,
    parameter int RST_SEL  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   locked,
    input  logic [NCH*DIV_W-1:0]   div,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   sel_req,
`ifdef LP805X_CLKEN_LOCKMON_EN
    input  logic                   lock_clr,
    output logic                   lock_lost,
    output logic [7:0]             lock_cnt,
`endif
    output logic                   sel_ack,
    output logic [SEL_W-1:0]       cur_sel,
    output logic                   ready,
    output logic [NCH-1:0]         ce_all,
    output logic                   ce
);

    localparam logic [15:0]      c_SETTLE_END = 16'(LOCK_CYC);
    localparam logic [SEL_W-1:0] c_RST_SEL    = SEL_W'(RST_SEL);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_SETTLE    = 2'd1,
        S_RUN       = 2'd2,
        S_SWITCH    = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_ready;
    logic             r_ack;
    logic [SEL_W-1:0] r_cur_sel;
    logic [SEL_W-1:0] r_pend;
    logic [15:0]      r_settle;

    logic [NCH-1:0]   w_hit;
    logic [NCH-1:0]   w_ce_all;
    logic             w_ce;
    logic             w_cnt_en;

    // Counters run only while ready and still locked, so a lock drop clears
    // them on the same edge that drops ready.
    assign w_cnt_en = r_ready & locked;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [DIV_W-1:0] w_div;
        logic [DIV_W-1:0] w_dm1;
        logic [DIV_W-1:0] r_cnt;

        assign w_div    = div[k*DIV_W +: DIV_W];
        assign w_dm1    = (w_div == '0) ? '0 : w_div - DIV_W'(1);
        assign w_hit[k] = (r_cnt >= w_dm1);

        always_ff @(posedge clk) begin
            if (!rst || !w_cnt_en) begin
                r_cnt <= '0;
            end else if (w_hit[k]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

    assign w_ce_all = {NCH{r_ready}} & w_hit;

    // During a switch only the pending channel may pulse; the old one is muted.
    always_comb begin
        w_ce = 1'b0;
        case (r_state)
            S_RUN:    w_ce = w_ce_all[r_cur_sel];
            S_SWITCH: w_ce = w_ce_all[r_pend];
            default:  w_ce = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_WAIT_LOCK;
            r_ready   <= 1'b0;
            r_ack     <= 1'b0;
            r_cur_sel <= c_RST_SEL;
            r_pend    <= c_RST_SEL;
            r_settle  <= '0;
        end else begin
            r_ack <= 1'b0;
            if (!locked) begin
                r_state <= S_WAIT_LOCK;
                r_ready <= 1'b0;
            end else begin
                case (r_state)
                    S_WAIT_LOCK: begin
                        r_state  <= S_SETTLE;
                        r_settle <= '0;
                    end
                    S_SETTLE: begin
                        if (r_settle == c_SETTLE_END) begin
                            r_state <= S_RUN;
                            r_ready <= 1'b1;
                        end else begin
                            r_settle <= r_settle + 16'd1;
                        end
                    end
                    S_RUN: begin
                        if (sel_req) begin
                            if (sel == r_cur_sel) begin
                                r_ack <= 1'b1;
                            end else begin
                                r_pend  <= sel;
                                r_state <= S_SWITCH;
                            end
                        end
                    end
                    S_SWITCH: begin
                        if (w_ce_all[r_pend]) begin
                            r_cur_sel <= r_pend;
                            r_ack     <= 1'b1;
                            r_state   <= S_RUN;
                        end
                    end
                    default: r_state <= S_WAIT_LOCK;
                endcase
            end
        end
    end

`ifdef LP805X_CLKEN_LOCKMON_EN
    logic       r_lock_lost;
    logic [7:0] r_lock_cnt;
    logic       w_lost_ev;

    assign w_lost_ev = r_ready & ~locked;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lock_lost <= 1'b0;
            r_lock_cnt  <= 8'd0;
        end else begin
            if (w_lost_ev) begin
                r_lock_lost <= 1'b1;
            end else if (lock_clr) begin
                r_lock_lost <= 1'b0;
            end
            // Clear then count: a coincident event leaves the count at one.
            if (lock_clr) begin
                r_lock_cnt <= w_lost_ev ? 8'd1 : 8'd0;
            end else if (w_lost_ev && (r_lock_cnt != 8'hFF)) begin
                r_lock_cnt <= r_lock_cnt + 8'd1;
            end
        end
    end

    assign lock_lost = r_lock_lost;
    assign lock_cnt  = r_lock_cnt;
`endif

    assign sel_ack = r_ack;
    assign cur_sel = r_cur_sel;
    assign ready   = r_ready;
    assign ce_all  = w_ce_all;
    assign ce      = w_ce;

endmodule
`default_nettype wire
